// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter in front of a single-port synchronous data memory.
//   Requester 0 is the CPU MEM stage and has default priority. Requester 1 is
//   a DMA/debug loader. A starvation counter forces one loader grant after
//   STARVE_LIMIT consecutive denied loader cycles. Read data returns one
//   cycle after a read grant and is steered to whichever requester issued it.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request channel
//   cpu_gnt, cpu_stall         CPU access issued / CPU request denied this cycle
//   cpu_rvalid, cpu_rdata      CPU read return (zero unless rvalid)
//   dma_req/we/addr/wdata      loader request channel
//   dma_gnt                    loader access issued this cycle
//   dma_rvalid, dma_rdata      loader read return (zero unless rvalid)
//   mem_en/we/addr/wdata       memory command, zero when idle
//   mem_rdata                  memory read data, valid the cycle after a read
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_reg, starve_cnt_next;
  // bit0: CPU read in flight, bit1: DMA read in flight
  logic [1:0] rsel_reg, rsel_next;
  logic       dma_prio;

  // Grants are masked while reset is low so nothing reaches the memory.
  always_comb begin
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    dma_prio = (starve_cnt_reg >= STARVE_LIM4);
    if (reset) begin
      if (dma_prio && dma_req) begin
        dma_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  assign cpu_stall = reset & cpu_req & ~cpu_gnt;

  always_comb begin
    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // Forced priority clears the counter on the loader grant, so it lasts
  // exactly one access.
  always_comb begin
    starve_cnt_next = 4'd0;
    if (dma_req && !dma_gnt) begin
      starve_cnt_next = (starve_cnt_reg == 4'd15) ? 4'd15 : starve_cnt_reg + 4'd1;
    end
    rsel_next = {dma_gnt & ~dma_we, cpu_gnt & ~cpu_we};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_reg <= 4'd0;
      rsel_reg       <= 2'b00;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      rsel_reg       <= rsel_next;
    end
  end

  // Read return steering; the shared memory bus is routed to one owner only.
  logic [1:0]            rvalid;
  logic [DATA_WIDTH-1:0] rdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_ret
    assign rvalid[gi] = rsel_reg[gi];
    assign rdata[gi]  = rsel_reg[gi] ? mem_rdata : '0;
  end

  assign cpu_rvalid = rvalid[0];
  assign cpu_rdata  = rdata[0];
  assign dma_rvalid = rvalid[1];
  assign dma_rdata  = rdata[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Bench for dmem_arbiter: directed scenarios with literal expectations,
//   then randomized traffic compared every cycle against a behavioural model
//   (loader wait count, shadow memory, one-deep read return).
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory attached to the arbiter.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------- behavioural model ----------------
  logic [DW-1:0] ref_mem [256];
  int            dma_wait;     // consecutive cycles the loader asked and lost
  logic          exp_cpu_rv, exp_dma_rv;
  logic [DW-1:0] exp_rd;

  // Who should own the memory now: {dma, cpu}.
  function automatic logic [1:0] model_gnt();
    if (!reset) return 2'b00;
    if (dma_req && (dma_wait >= LIM || !cpu_req)) return 2'b10;
    if (cpu_req) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dma_wait   = 0;
      exp_cpu_rv = 1'b0;
      exp_dma_rv = 1'b0;
    end else begin
      logic [1:0] g;
      g = model_gnt();
      exp_cpu_rv = g[0] && !cpu_we;
      exp_dma_rv = g[1] && !dma_we;
      if (g[0]) begin
        if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
        else        exp_rd = ref_mem[cpu_addr];
      end else if (g[1]) begin
        if (dma_we) ref_mem[dma_addr] = dma_wdata;
        else        exp_rd = ref_mem[dma_addr];
      end
      if (dma_req && !g[1]) dma_wait = (dma_wait >= 15) ? 15 : dma_wait + 1;
      else                  dma_wait = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [1:0]    g;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    g = model_gnt();
    e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (g[0]) begin e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
    else if (g[1]) begin e_we = dma_we; e_addr = dma_addr; e_wd = dma_wdata; end
    check("cpu_gnt", 32'(cpu_gnt), 32'(g[0]));
    check("dma_gnt", 32'(dma_gnt), 32'(g[1]));
    check("cpu_stall", 32'(cpu_stall), 32'(reset && cpu_req && !g[0]));
    check("mem_en", 32'(mem_en), 32'(g[0] | g[1]));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cpu_rv));
    check("dma_rvalid", 32'(dma_rvalid), 32'(exp_dma_rv));
    check("cpu_rdata", 32'(cpu_rdata), exp_cpu_rv ? 32'(exp_rd) : 32'd0);
    check("dma_rdata", 32'(dma_rdata), exp_dma_rv ? 32'(exp_rd) : 32'd0);
    if (mem_en)
      $display("txn t=%0t owner=%s we=%0d addr=%h wdata=%h", $time,
               cpu_gnt ? "cpu" : "dma", mem_we, mem_addr, mem_wdata);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h10] = 16'hBEEF;
    mem[8'h01] = 16'h0A0A;
    mem[8'h02] = 16'h0B0B;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    mem_rdata = '0;

    // Reset held: both requesting, nothing may issue.
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = 16'h0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_cpu_gnt", 32'(cpu_gnt), 0);
    check("rst_dma_gnt", 32'(dma_gnt), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_cpu_stall", 32'(cpu_stall), 0);

    // Release: CPU read of 0x10 granted immediately.
    tick(); reset = 1'b1;
    @(negedge clk);
    check("rel_cpu_gnt", 32'(cpu_gnt), 1);
    check("rel_dma_gnt", 32'(dma_gnt), 0);
    check("rel_mem_addr", 32'(mem_addr), 32'h10);
    tick(); cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    check("rd_cpu_rvalid", 32'(cpu_rvalid), 1);
    check("rd_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    check("rd_dma_rvalid", 32'(dma_rvalid), 0);
    check("model_rv", 32'(exp_cpu_rv), 1);
    check("model_rd", 32'(exp_rd), 32'hBEEF);

    // DMA write without contention, then CPU reads it back.
    tick(); dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h20; dma_wdata = 16'h1234;
    @(negedge clk);
    check("dw_dma_gnt", 32'(dma_gnt), 1);
    check("dw_mem_we", 32'(mem_we), 1);
    check("dw_mem_wdata", 32'(mem_wdata), 32'h1234);
    tick(); dma_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
    @(negedge clk);
    check("dw_no_rvalid", 32'(dma_rvalid), 0);
    check("dw_cpu_gnt", 32'(cpu_gnt), 1);
    tick(); cpu_req = 1'b0;
    @(negedge clk);
    check("dw_cpu_rvalid", 32'(cpu_rvalid), 1);
    check("dw_cpu_rdata", 32'(cpu_rdata), 32'h1234);

    // Continuous contention: loader wins every fifth cycle.
    tick(); cpu_req = 1'b1; cpu_addr = 8'h00; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h03;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("starve_dma_gnt", 32'(dma_gnt), (k % 5 == 4) ? 1 : 0);
      check("starve_cpu_stall", 32'(cpu_stall), (k % 5 == 4) ? 1 : 0);
    end
    tick(); cpu_req = 1'b0; dma_req = 1'b0;

    // Back-to-back reads with alternating owners.
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    @(negedge clk);
    check("b2b_cpu_gnt", 32'(cpu_gnt), 1);
    tick(); cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'h02;
    @(negedge clk);
    check("b2b_cpu_rvalid", 32'(cpu_rvalid), 1);
    check("b2b_cpu_rdata", 32'(cpu_rdata), 32'h0A0A);
    check("b2b_dma_gnt", 32'(dma_gnt), 1);
    check("b2b_dma_rvalid0", 32'(dma_rvalid), 0);
    tick(); dma_req = 1'b0;
    @(negedge clk);
    check("b2b_dma_rvalid", 32'(dma_rvalid), 1);
    check("b2b_dma_rdata", 32'(dma_rdata), 32'h0B0B);
    check("b2b_cpu_rvalid1", 32'(cpu_rvalid), 0);

    // Reset arriving while a CPU read is in flight.
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    @(negedge clk);
    check("mid_cpu_gnt", 32'(cpu_gnt), 1);
    #2; reset = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check("mid_cpu_rvalid", 32'(cpu_rvalid), 0);
    tick(); reset = 1'b1;
    @(negedge clk);
    check("mid_cpu_rvalid_rel", 32'(cpu_rvalid), 0);
    check("mid_starve_cnt", 32'(dut.starve_cnt_reg), 0);

    // Randomized traffic, including occasional reset pulses.
    for (int n = 0; n < 1500; n++) begin
      tick();
      reset     = ($urandom_range(0, 99) != 0);
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = 8'($urandom_range(0, 15));
      cpu_wdata = 16'($urandom);
      dma_req   = ($urandom_range(0, 4) > 1);
      dma_we    = $urandom_range(0, 1) == 1;
      dma_addr  = 8'($urandom_range(0, 15));
      dma_wdata = 16'($urandom);
    end
    tick(); reset = 1'b1; cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
